// File: rtl/rv_mc_main_ctrl.sv
// Main controller for the multicycle RV32I core: instruction-sequencing FSM,
// IR decode into datapath controls, illegal-instruction trap and instret counter.
module rv_mc_main_ctrl #(
  parameter int XLEN            = 32,
  parameter bit USE_MEM_READY   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      i_instr,
  input  logic             i_mem_ready,
  input  logic             i_alu_zero,
  input  logic             i_alu_lt,
  input  logic             i_alu_ltu,
  output logic [3:0]       o_state,
  output logic             o_pc_write,
  output logic             o_adr_src,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_ir_write,
  output logic [1:0]       o_result_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [3:0]       o_alu_ctrl,
  output logic             o_reg_write,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instret
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
    S_LUI = 4'd12, S_AUIPC = 4'd13, S_TRAP = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R    = 7'b0110011, OP_I     = 7'b0010011,
                         OP_BR   = 7'b1100011, OP_JAL   = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111,
                         OP_AUIPC = 7'b0010111;

  state_t              r_state;
  state_t              w_next;
  state_t              w_dec_next;
  logic [CNT_W-1:0]    r_instret;
  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic                w_ready;
  logic                w_bad_instr;
  logic                w_taken;
  logic [31:0]         w_imm32;
  logic                w_pc_write, w_adr_src, w_mem_req, w_mem_we, w_ir_write;
  logic                w_reg_write, w_trap;
  logic [1:0]          w_result_src, w_alu_src_a, w_alu_src_b;
  logic [3:0]          w_alu_ctrl;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_ready  = USE_MEM_READY ? i_mem_ready : 1'b1;

  function automatic logic [3:0] aluOp(input logic [2:0] f3, input logic sub, input logic sra);
    case (f3)
      3'b000:  aluOp = sub ? 4'd1 : 4'd0;
      3'b001:  aluOp = 4'd7;
      3'b010:  aluOp = 4'd5;
      3'b011:  aluOp = 4'd6;
      3'b100:  aluOp = 4'd4;
      3'b101:  aluOp = sra ? 4'd9 : 4'd8;
      3'b110:  aluOp = 4'd3;
      default: aluOp = 4'd2;
    endcase
  endfunction

  // Class and legality are resolved in DECODE, while the IR is known to be stable.
  always_comb begin
    w_dec_next  = S_FETCH;
    w_bad_instr = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_STORE: w_dec_next = S_MEMADR;
      OP_R: begin
        w_dec_next  = S_EXECR;
        w_bad_instr = !((w_funct7 == 7'h00) ||
                        ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
      end
      OP_I:     w_dec_next = S_EXECI;
      OP_BR: begin
        w_dec_next  = S_BRANCH;
        w_bad_instr = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      OP_JAL:   w_dec_next = S_JAL;
      OP_JALR:  w_dec_next = S_JALR;
      OP_LUI:   w_dec_next = S_LUI;
      OP_AUIPC: w_dec_next = S_AUIPC;
      default:  w_bad_instr = 1'b1;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = w_bad_instr ? (TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH) : w_dec_next;
      S_MEMADR:   w_next = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: w_next = S_ALUWB;
      S_ALUWB, S_BRANCH: w_next = S_FETCH;
      S_JALR:     w_next = S_JAL;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next == S_FETCH) && (r_state != S_FETCH))
        r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    case (w_funct3)
      3'b000:  w_taken = i_alu_zero;
      3'b001:  w_taken = !i_alu_zero;
      3'b100:  w_taken = i_alu_lt;
      3'b101:  w_taken = !i_alu_lt;
      3'b110:  w_taken = i_alu_ltu;
      3'b111:  w_taken = !i_alu_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_write = 1'b0; w_adr_src = 1'b0; w_mem_req = 1'b0; w_mem_we = 1'b0;
    w_ir_write = 1'b0; w_reg_write = 1'b0; w_trap = 1'b0;
    w_result_src = 2'd0; w_alu_src_a = 2'd0; w_alu_src_b = 2'd0; w_alu_ctrl = 4'd0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1; w_alu_src_b = 2'd2; w_result_src = 2'd2;
        w_ir_write = w_ready; w_pc_write = w_ready;
      end
      S_DECODE:   begin w_alu_src_a = 2'd1; w_alu_src_b = 2'd1; end
      S_MEMADR:   begin w_alu_src_a = 2'd2; w_alu_src_b = 2'd1; end
      S_MEMREAD:  begin w_adr_src = 1'b1; w_mem_req = 1'b1; end
      S_MEMWB:    begin w_result_src = 2'd1; w_reg_write = 1'b1; end
      S_MEMWRITE: begin w_adr_src = 1'b1; w_mem_req = 1'b1; w_mem_we = 1'b1; end
      S_EXECR: begin
        w_alu_src_a = 2'd2;
        w_alu_ctrl  = aluOp(w_funct3, i_instr[30], i_instr[30]);
      end
      S_EXECI: begin
        w_alu_src_a = 2'd2; w_alu_src_b = 2'd1;
        w_alu_ctrl  = aluOp(w_funct3, 1'b0, i_instr[30]);
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_BRANCH: begin w_alu_src_a = 2'd2; w_alu_ctrl = 4'd1; w_pc_write = w_taken; end
      S_JAL:    begin w_alu_src_a = 2'd1; w_alu_src_b = 2'd2; w_pc_write = 1'b1; end
      S_JALR:   begin w_alu_src_a = 2'd2; w_alu_src_b = 2'd1; end
      S_LUI:    begin w_alu_src_a = 2'd3; w_alu_src_b = 2'd1; end
      S_AUIPC:  begin w_alu_src_a = 2'd1; w_alu_src_b = 2'd1; end
      S_TRAP:   w_trap = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    w_imm32 = 32'd0;
    case (w_opcode)
      OP_LOAD, OP_I, OP_JALR: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      OP_STORE: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OP_BR:    w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: w_imm32 = {i_instr[31:12], 12'd0};
      OP_JAL:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
      default:  w_imm32 = 32'd0;
    endcase
  end

  // Strobes are masked combinationally so they drop in the very cycle reset is asserted.
  assign o_pc_write   = w_pc_write  & resetn;
  assign o_mem_req    = w_mem_req   & resetn;
  assign o_mem_we     = w_mem_we    & resetn;
  assign o_ir_write   = w_ir_write  & resetn;
  assign o_reg_write  = w_reg_write & resetn;
  assign o_illegal    = w_trap      & resetn;
  assign o_adr_src    = w_adr_src;
  assign o_result_src = w_result_src;
  assign o_alu_src_a  = w_alu_src_a;
  assign o_alu_src_b  = w_alu_src_b;
  assign o_alu_ctrl   = w_alu_ctrl;
  assign o_state      = r_state;
  assign o_instret    = r_instret;
  assign o_imm        = XLEN'($signed(w_imm32));

endmodule

// File: tb/tb_rv_mc_main_ctrl.sv
// Directed, table-driven bench for rv_mc_main_ctrl: one record per clock cycle
// with hand-computed expected controls, followed by a stalled-load sequence.
module tb_rv_mc_main_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, adr, req, we, irw;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
    logic rw, ill;
  } outs_t;

  typedef struct {
    logic        rstn;
    logic [31:0] instr;
    logic [3:0]  flags;
    outs_t       exp;
    logic [31:0] imm;
    logic [31:0] cnt;
  } vec_t;

  localparam logic [31:0] I_ADD = 32'h002081B3, I_LW = 32'h0002A303, I_BEQ = 32'h00208463,
    I_BLT = 32'h0020C463, I_BGEU = 32'h0020F463, I_JAL = 32'h008000EF, I_SUB = 32'h40208233,
    I_SRAI = 32'h4031D213, I_LUI = 32'h123450B7, I_ADDI = 32'hFFF00093, I_JALR = 32'h000280E7,
    I_AUIPC = 32'h00001117, I_SW = 32'h0062A223, I_BBAD = 32'h0020A463, I_ZERO = 32'h0;

  logic clk = 1'b0, resetn = 1'b0;
  logic [31:0] instr = '0;
  logic memReady = 1'b0, aluZero = 1'b0, aluLt = 1'b0, aluLtu = 1'b0;
  logic [3:0] state, aluCtrl;
  logic pcWrite, adrSrc, memReq, memWe, irWrite, regWrite, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [31:0] imm, instret;
  outs_t act;
  vec_t vecs[$];
  int nVec = 0, nBad = 0;

  rv_mc_main_ctrl #(.XLEN(32), .USE_MEM_READY(1'b1), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .i_instr(instr), .i_mem_ready(memReady),
    .i_alu_zero(aluZero), .i_alu_lt(aluLt), .i_alu_ltu(aluLtu),
    .o_state(state), .o_pc_write(pcWrite), .o_adr_src(adrSrc), .o_mem_req(memReq),
    .o_mem_we(memWe), .o_ir_write(irWrite), .o_result_src(resultSrc),
    .o_alu_src_a(aluSrcA), .o_alu_src_b(aluSrcB), .o_alu_ctrl(aluCtrl),
    .o_reg_write(regWrite), .o_imm(imm), .o_illegal(illegal), .o_instret(instret)
  );

  always #5 clk = ~clk;

  assign act = {state, pcWrite, adrSrc, memReq, memWe, irWrite, resultSrc, aluSrcA, aluSrcB,
                aluCtrl, regWrite, illegal};

  // strobes packed as {pc_write, adr_src, mem_req, mem_we, ir_write}
  function automatic outs_t oo(logic [3:0] st, logic [4:0] s, logic [1:0] rs, logic [1:0] sa,
                               logic [1:0] sb, logic [3:0] alu, logic rw, logic ill);
    oo = {st, s, rs, sa, sb, alu, rw, ill};
  endfunction

  // flags packed as {mem_ready, alu_zero, alu_lt, alu_ltu}
  function automatic vec_t mk(logic rstn, logic [31:0] ins, logic [3:0] flags, outs_t e,
                              logic [31:0] im, logic [31:0] cnt);
    vec_t v;
    v.rstn = rstn; v.instr = ins; v.flags = flags; v.exp = e; v.imm = im; v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t fetchRow(logic [31:0] ins, logic [31:0] im, logic [31:0] cnt, logic rdy);
    return mk(1'b1, ins, {rdy, 3'b000}, oo(4'd0, {rdy, 1'b0, 1'b1, 1'b0, rdy}, 2'd2, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0), im, cnt);
  endfunction

  function automatic vec_t decodeRow(logic [31:0] ins, logic [31:0] im, logic [31:0] cnt);
    return mk(1'b1, ins, 4'b1000, oo(4'd1, 5'b0, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0), im, cnt);
  endfunction

  function automatic vec_t aluwbRow(logic [31:0] ins, logic [31:0] im, logic [31:0] cnt);
    return mk(1'b1, ins, 4'b1000, oo(4'd8, 5'b0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0), im, cnt);
  endfunction

  task automatic applyStimulus(input vec_t v);
    resetn = v.rstn;
    instr  = v.instr;
    {memReady, aluZero, aluLt, aluLtu} = v.flags;
  endtask

  task automatic checkOutput(input string name, input logic [95:0] got, input logic [95:0] want);
    nVec++;
    if (got !== want) begin
      nBad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k;
    int held;

    // add: reset, then FETCH DECODE EXECR ALUWB
    vecs.push_back(mk(1'b0, I_ADD, 4'b1000, oo(4'd0, 5'b0, 2'd2, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0), 32'd0, 32'd0));
    vecs.push_back(fetchRow(I_ADD, 32'd0, 32'd0, 1'b1));
    vecs.push_back(decodeRow(I_ADD, 32'd0, 32'd0));
    vecs.push_back(mk(1'b1, I_ADD, 4'b1000, oo(4'd6, 5'b0, 2'd0, 2'd2, 2'd0, 4'd0, 1'b0, 1'b0), 32'd0, 32'd0));
    vecs.push_back(aluwbRow(I_ADD, 32'd0, 32'd0));
    // lw with mem_ready low 3 cycles in MEMREAD
    vecs.push_back(fetchRow(I_LW, 32'd0, 32'd1, 1'b1));
    vecs.push_back(decodeRow(I_LW, 32'd0, 32'd1));
    vecs.push_back(mk(1'b1, I_LW, 4'b1000, oo(4'd2, 5'b0, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0), 32'd0, 32'd1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, I_LW, 4'b0000, oo(4'd3, 5'b01100, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0), 32'd0, 32'd1));
    vecs.push_back(mk(1'b1, I_LW, 4'b1000, oo(4'd3, 5'b01100, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0), 32'd0, 32'd1));
    vecs.push_back(mk(1'b1, I_LW, 4'b1000, oo(4'd4, 5'b0, 2'd1, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0), 32'd0, 32'd1));
    // beq taken / not taken, blt taken, bgeu not taken
    vecs.push_back(fetchRow(I_BEQ, 32'd8, 32'd2, 1'b1));
    vecs.push_back(decodeRow(I_BEQ, 32'd8, 32'd2));
    vecs.push_back(mk(1'b1, I_BEQ, 4'b1100, oo(4'd9, 5'b10000, 2'd0, 2'd2, 2'd0, 4'd1, 1'b0, 1'b0), 32'd8, 32'd2));
    vecs.push_back(fetchRow(I_BEQ, 32'd8, 32'd3, 1'b1));
    vecs.push_back(decodeRow(I_BEQ, 32'd8, 32'd3));
    vecs.push_back(mk(1'b1, I_BEQ, 4'b1000, oo(4'd9, 5'b00000, 2'd0, 2'd2, 2'd0, 4'd1, 1'b0, 1'b0), 32'd8, 32'd3));
    vecs.push_back(fetchRow(I_BLT, 32'd8, 32'd4, 1'b1));
    vecs.push_back(decodeRow(I_BLT, 32'd8, 32'd4));
    vecs.push_back(mk(1'b1, I_BLT, 4'b1010, oo(4'd9, 5'b10000, 2'd0, 2'd2, 2'd0, 4'd1, 1'b0, 1'b0), 32'd8, 32'd4));
    vecs.push_back(fetchRow(I_BGEU, 32'd8, 32'd5, 1'b1));
    vecs.push_back(decodeRow(I_BGEU, 32'd8, 32'd5));
    vecs.push_back(mk(1'b1, I_BGEU, 4'b1111, oo(4'd9, 5'b00000, 2'd0, 2'd2, 2'd0, 4'd1, 1'b0, 1'b0), 32'd8, 32'd5));
    // jal: DECODE JAL ALUWB
    vecs.push_back(fetchRow(I_JAL, 32'd8, 32'd6, 1'b1));
    vecs.push_back(decodeRow(I_JAL, 32'd8, 32'd6));
    vecs.push_back(mk(1'b1, I_JAL, 4'b1000, oo(4'd10, 5'b10000, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0, 1'b0), 32'd8, 32'd6));
    vecs.push_back(aluwbRow(I_JAL, 32'd8, 32'd6));
    // sub -> SUB, srai -> SRA
    vecs.push_back(fetchRow(I_SUB, 32'd0, 32'd7, 1'b1));
    vecs.push_back(decodeRow(I_SUB, 32'd0, 32'd7));
    vecs.push_back(mk(1'b1, I_SUB, 4'b1000, oo(4'd6, 5'b0, 2'd0, 2'd2, 2'd0, 4'd1, 1'b0, 1'b0), 32'd0, 32'd7));
    vecs.push_back(aluwbRow(I_SUB, 32'd0, 32'd7));
    vecs.push_back(fetchRow(I_SRAI, 32'h403, 32'd8, 1'b1));
    vecs.push_back(decodeRow(I_SRAI, 32'h403, 32'd8));
    vecs.push_back(mk(1'b1, I_SRAI, 4'b1000, oo(4'd7, 5'b0, 2'd0, 2'd2, 2'd1, 4'd9, 1'b0, 1'b0), 32'h403, 32'd8));
    vecs.push_back(aluwbRow(I_SRAI, 32'h403, 32'd8));
    // lui, addi -1, jalr, auipc
    vecs.push_back(fetchRow(I_LUI, 32'h12345000, 32'd9, 1'b1));
    vecs.push_back(decodeRow(I_LUI, 32'h12345000, 32'd9));
    vecs.push_back(mk(1'b1, I_LUI, 4'b1000, oo(4'd12, 5'b0, 2'd0, 2'd3, 2'd1, 4'd0, 1'b0, 1'b0), 32'h12345000, 32'd9));
    vecs.push_back(aluwbRow(I_LUI, 32'h12345000, 32'd9));
    vecs.push_back(fetchRow(I_ADDI, 32'hFFFFFFFF, 32'd10, 1'b1));
    vecs.push_back(decodeRow(I_ADDI, 32'hFFFFFFFF, 32'd10));
    vecs.push_back(mk(1'b1, I_ADDI, 4'b1000, oo(4'd7, 5'b0, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0), 32'hFFFFFFFF, 32'd10));
    vecs.push_back(aluwbRow(I_ADDI, 32'hFFFFFFFF, 32'd10));
    vecs.push_back(fetchRow(I_JALR, 32'd0, 32'd11, 1'b1));
    vecs.push_back(decodeRow(I_JALR, 32'd0, 32'd11));
    vecs.push_back(mk(1'b1, I_JALR, 4'b1000, oo(4'd11, 5'b0, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0), 32'd0, 32'd11));
    vecs.push_back(mk(1'b1, I_JALR, 4'b1000, oo(4'd10, 5'b10000, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0, 1'b0), 32'd0, 32'd11));
    vecs.push_back(aluwbRow(I_JALR, 32'd0, 32'd11));
    vecs.push_back(fetchRow(I_AUIPC, 32'h1000, 32'd12, 1'b1));
    vecs.push_back(decodeRow(I_AUIPC, 32'h1000, 32'd12));
    vecs.push_back(mk(1'b1, I_AUIPC, 4'b1000, oo(4'd13, 5'b0, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0), 32'h1000, 32'd12));
    vecs.push_back(aluwbRow(I_AUIPC, 32'h1000, 32'd12));
    // sw with one stalled fetch cycle
    vecs.push_back(fetchRow(I_SW, 32'd4, 32'd13, 1'b0));
    vecs.push_back(fetchRow(I_SW, 32'd4, 32'd13, 1'b1));
    vecs.push_back(decodeRow(I_SW, 32'd4, 32'd13));
    vecs.push_back(mk(1'b1, I_SW, 4'b1000, oo(4'd2, 5'b0, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0), 32'd4, 32'd13));
    vecs.push_back(mk(1'b1, I_SW, 4'b1000, oo(4'd5, 5'b01110, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0), 32'd4, 32'd13));
    // branch with funct3 010 traps; reset is the only way out
    vecs.push_back(fetchRow(I_BBAD, 32'd8, 32'd14, 1'b1));
    vecs.push_back(decodeRow(I_BBAD, 32'd8, 32'd14));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1'b1, I_BBAD, 4'b1000, oo(4'd14, 5'b0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1), 32'd8, 32'd14));
    vecs.push_back(mk(1'b0, I_BBAD, 4'b1000, oo(4'd14, 5'b0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0), 32'd8, 32'd14));
    // reset asserted mid-store with mem_ready low
    vecs.push_back(fetchRow(I_SW, 32'd4, 32'd0, 1'b1));
    vecs.push_back(decodeRow(I_SW, 32'd4, 32'd0));
    vecs.push_back(mk(1'b1, I_SW, 4'b1000, oo(4'd2, 5'b0, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0), 32'd4, 32'd0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1'b1, I_SW, 4'b0000, oo(4'd5, 5'b01110, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0), 32'd4, 32'd0));
    vecs.push_back(mk(1'b0, I_SW, 4'b0000, oo(4'd5, 5'b01000, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0), 32'd4, 32'd0));
    vecs.push_back(mk(1'b0, I_SW, 4'b0000, oo(4'd0, 5'b0, 2'd2, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0), 32'd4, 32'd0));
    // all-zero word is illegal: TRAP held, instret frozen
    vecs.push_back(fetchRow(I_ZERO, 32'd0, 32'd0, 1'b1));
    vecs.push_back(decodeRow(I_ZERO, 32'd0, 32'd0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1'b1, I_ZERO, 4'b1000, oo(4'd14, 5'b0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1), 32'd0, 32'd0));

    $display("[TB] applying %0d table vectors", vecs.size());
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("vec%0d", i), {11'b0, act, imm, instret},
                  {11'b0, vecs[i].exp, vecs[i].imm, vecs[i].cnt});
    end

    // Load stalled 5 cycles in MEMREAD, reached via a bounded wait.
    @(negedge clk);
    resetn = 1'b0; instr = I_LW; memReady = 1'b1;
    {aluZero, aluLt, aluLtu} = 3'b000;
    @(negedge clk);
    resetn = 1'b1;
    #2;
    k = 0;
    while (state != 4'd3 && k < 10) begin
      @(negedge clk); #2; k++;
    end
    checkOutput("reach_memread", 96'(state), 96'd3);
    memReady = 1'b0;
    held = 0;
    repeat (5) begin
      if (state == 4'd3 && memReq && adrSrc) held++;
      @(negedge clk); #2;
    end
    checkOutput("memread_held", 96'(held), 96'd5);
    checkOutput("memread_still", 96'({state, memReq}), 96'({4'd3, 1'b1}));
    memReady = 1'b1;
    @(negedge clk); #2;
    checkOutput("memwb", 96'({state, resultSrc, regWrite}), 96'({4'd4, 2'd1, 1'b1}));
    @(negedge clk); #2;
    checkOutput("lw_retired", 96'({state, memReq, instret}), 96'({4'd0, 1'b1, 32'd1}));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/rv_mc_main_ctrl.md
Name: rv_mc_main_ctrl

Overview:
Parametrised main controller for the multicycle RV32I core. It holds the instruction-sequencing FSM and decodes the IR into datapath control: ALU operation, mux selects, immediate and write strobes. It adds a memory ready handshake, full RV32I class coverage, illegal-instruction trapping and a retired-instruction counter. It sits between the instruction register/ALU flags and the core datapath muxes.

Parameters:
XLEN, 32, datapath width; immediates sign-extended to XLEN; must be >= 32.
USE_MEM_READY, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1.
TRAP_ON_ILLEGAL, 1, 1: illegal instruction enters TRAP; 0: illegal instruction retires as NOP.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock.
resetn  in  1  synchronous, active-low reset.
instr  in  32  IR contents.
mem_ready  in  1  memory completed the current request this cycle.
alu_zero  in  1  ALU result == 0.
alu_lt  in  1  signed rs1 < rs2.
alu_ltu  in  1  unsigned rs1 < rs2.
state  out  4  FSM state code.
pc_write  out  1  load PC.
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
mem_req  out  1  memory request.
mem_we  out  1  memory write.
ir_write  out  1  load IR and OldPC.
result_src  out  2  result select: 0 = ALUOut, 1 = mem data, 2 = ALU result.
alu_src_a  out  2  ALU A select: 0 = PC, 1 = OldPC, 2 = rs1, 3 = zero.
alu_src_b  out  2  ALU B select: 0 = rs2, 1 = imm, 2 = constant 4.
alu_ctrl  out  4  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
reg_write  out  1  register file write.
imm  out  XLEN  decoded immediate.
illegal  out  1  in TRAP.
instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: state = FETCH(0), instret = 0. All strobes (pc_write, mem_req, mem_we, ir_write, reg_write, illegal) are forced 0 while resetn = 0. The first fetch is driven in the cycle after release. Reset in any state, including mid-memory access, aborts the operation.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, AUIPC 13, TRAP 14. Codes 15 and above go to FETCH.
- All outputs are Moore outputs of the state, except:
  - handshake-qualified strobes;
  - branch pc_write;
  - alu_ctrl in EXECR/EXECI;
  - imm, which is always combinational from instr.
- Outputs not listed for a state are 0.
- FETCH: adr_src=0, mem_req=1, a=0, b=2, ADD, result_src=2. ir_write and pc_write equal mem_ready. On mem_ready go to DECODE; otherwise hold.
- DECODE: a=1, b=1, ADD (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - else illegal.
- MEMADR: a=2, b=1, ADD. Loads go to MEMREAD, stores to MEMWRITE.
- MEMREAD: adr_src=1, mem_req=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=1, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, mem_req=1, mem_we=1. Hold until mem_ready, then FETCH.
- EXECR: a=2, b=0, alu_ctrl from funct3/funct7[5] -> ALUWB.
  - Mapping: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - funct7 other than 0x00 or 0x20 (0x20 only with funct3 000 or 101) is illegal.
- EXECI: a=2, b=1 -> ALUWB. Same mapping as EXECR, except funct7[5] selects only SRA vs SRL and never SUB.
- ALUWB: result_src=0, reg_write=1 -> FETCH.
- BRANCH: a=2, b=0, SUB, result_src=0 -> FETCH.
  - pc_write = taken, by funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
  - funct3 010/011 is illegal.
- JAL: a=1, b=2, ADD, result_src=0, pc_write=1 -> ALUWB (writes OldPC+4).
- JALR: a=2, b=1, ADD -> JAL.
- LUI: a=3, b=1, ADD -> ALUWB.
- AUIPC: a=1, b=1, ADD -> ALUWB.
- Illegal instruction:
  - TRAP_ON_ILLEGAL=1: go to TRAP; illegal=1, no strobes; remain in TRAP until reset.
  - TRAP_ON_ILLEGAL=0: go to FETCH and count as retired.
- imm by opcode, sign-extended from instr[31]:
  - I: [31:20]
  - S: {[31:25], [11:7]}
  - B: {[31], [7], [30:25], [11:8], 0}
  - U: {[31:12], 12'b0}
  - J: {[31], [19:12], [20], [30:21], 0}
  - Other opcodes: 0.
- instret increments by 1 (wrapping modulo 2^CNT_W) on every transition into FETCH from a non-FETCH state.

Test Plan:
- Reset, mem_ready=1, instr 0x002081B3 (add) -> states 0,1,6,8,0; alu_ctrl=0 in EXECR; reg_write=1 only in ALUWB; instret=1.
- instr 0x0002A303 (lw), mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_req=1, adr_src=1; then MEMWB with result_src=1, reg_write=1; imm=0.
- instr 0x00208463 (beq), imm=8: alu_zero=1 -> pc_write=1 in BRANCH; alu_zero=0 -> pc_write=0; both return to FETCH.
- instr 0x008000EF (jal) -> imm=8; states 1,10,8; pc_write=1 in JAL; ALUWB writes; instret+1.
- instr 0x40208233 -> alu_ctrl=1; instr 0x4031D213 -> alu_ctrl=9; instr 0x00000000 with TRAP_ON_ILLEGAL=1 -> state 14, illegal=1 for 10+ cycles, instret frozen.
- Reset asserted in MEMWRITE with mem_ready=0 -> next cycle all strobes 0, state 0; first FETCH mem_req=1 after release.
